// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between a pipeline
// request port and a 32-bit byte-enabled RAM port.
// Optional feature: define MAU_MISALIGN_CHECK_EN to reject misaligned half and
// word accesses with resp_err (no RAM cycle). With the macro undefined, the low
// address bits that would cause misalignment are ignored and every request issues.
module mem_access_unit #(
    parameter int RD_LATENCY = 1   // cycles from data_en to valid data_rdata, 1..3
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active low
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        data_en,
    output logic [3:0]  data_wen,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;

    logic [1:0]  acc_off;
    logic        acc_mis;
    logic [3:0]  acc_wen;
    logic [31:0] acc_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Decode an incoming request: lane offset, byte enables, replicated data, alignment.
    always_comb begin
        acc_off   = 2'b00;
        acc_mis   = 1'b0;
        acc_wen   = 4'b1111;
        acc_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                acc_off   = req_addr[1:0];
                acc_wen   = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                acc_off   = {req_addr[1], 1'b0};
                acc_wen   = 4'b0011 << {req_addr[1], 1'b0};
                acc_wdata = {2{req_wdata[15:0]}};
`ifdef MAU_MISALIGN_CHECK_EN
                acc_mis   = req_addr[0];
`endif
            end
            default: begin
`ifdef MAU_MISALIGN_CHECK_EN
                acc_mis   = |req_addr[1:0];
`endif
            end
        endcase
        if (!req_we) acc_wen = 4'b0000;
    end

    // Align the returned RAM word to bit 0 and extend to 32 bits.
    always_comb begin
        shifted = data_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'b0, shifted[7:0]};
            2'd1:    load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Control FSM; every output is a register so reset clears them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            off_q      <= 2'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            data_en    <= 1'b0;
            data_wen   <= 4'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        off_q     <= acc_off;
                        req_ready <= 1'b0;
                        if (acc_mis) begin
                            // Misaligned: answer straight away, never touch the RAM.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state      <= ISSUE;
                            data_en    <= 1'b1;
                            data_wen   <= acc_wen;
                            data_addr  <= {req_addr[31:2], 2'b00};
                            data_wdata <= req_we ? acc_wdata : 32'd0;
                        end
                    end
                end
                ISSUE: begin
                    data_en  <= 1'b0;
                    data_wen <= 4'd0;
                    if (we_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses are queued when a
// request is driven and checked when the response handshake occurs.
module tb_mem_access_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .data_en(data_en),
        .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    // One transaction: drive, track RAM port activity, check latency and handshake.
    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_en, input logic [31:0] exp_addr,
                        input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int hold);
        int cyc, en_cnt;
        logic [31:0] en_addr, en_wdata;
        logic [3:0]  en_wen;
        exp_t e;
        en_cnt = 0; en_addr = '0; en_wdata = '0; en_wen = '0;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        resp_ready = (hold == 0);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        e.rdata = exp_rdata; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (data_en) begin
                en_cnt++;
                en_addr = data_addr; en_wen = data_wen; en_wdata = data_wdata;
            end
            if (resp_valid) break;
            if (cyc > 20) begin
                chk("resp_timeout", 32'd1, 32'd0);
                break;
            end
        end
        chk("resp_latency", cyc, exp_lat);
        chk("issue_count", en_cnt, exp_en);
        if (exp_en != 0) begin
            chk("data_addr", en_addr, exp_addr);
            chk("data_wen", {28'd0, en_wen}, {28'd0, exp_wen});
            if (we) chk("data_wdata", en_wdata, exp_wdata);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_rdata);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        if (hold != 0) begin
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("resp_valid_after", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1; data_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data_en", {31'd0, data_en}, 32'd0);
        chk("rst_data_wen", {28'd0, data_wen}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        rst = 1'b1;

        // word store
        xact(1, 2, 0, 32'h100, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 2, 0);
        // byte loads at lane 3, signed and unsigned
        data_rdata = 32'h80112233;
        xact(0, 0, 1, 32'h103, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 2 + LAT, 0);
        xact(0, 0, 0, 32'h103, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h00000080, 0, 2 + LAT, 0);
        // half store upper lanes
        xact(1, 1, 0, 32'h202, 32'h0000ABCD, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 0, 2, 0);
        // byte store lane 1
        xact(1, 0, 0, 32'h101, 32'h12345A5A, 1, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0, 0, 2, 0);
        // word load at misaligned address
        data_rdata = 32'h12345678;
`ifdef MAU_MISALIGN_CHECK_EN
        xact(0, 2, 0, 32'h101, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1, 0);
        xact(0, 1, 1, 32'h103, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1, 0);
`else
        xact(0, 2, 0, 32'h101, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h12345678, 0, 2 + LAT, 0);
        xact(0, 1, 1, 32'h103, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h00001234, 0, 2 + LAT, 0);
`endif
        // half loads, sign and zero extension
        data_rdata = 32'h80017FFF;
        xact(0, 1, 1, 32'h102, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'hFFFF8001, 0, 2 + LAT, 0);
        xact(0, 1, 0, 32'h100, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h00007FFF, 0, 2 + LAT, 0);
        // size 3 behaves as word
        data_rdata = 32'hCAFEF00D;
        xact(0, 3, 1, 32'h104, 32'h0, 1, 32'h104, 4'b0000, 32'h0, 32'hCAFEF00D, 0, 2 + LAT, 0);
        // back-pressured load: response must hold for 5 cycles
        data_rdata = 32'h80112233;
        xact(0, 0, 0, 32'h100, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h00000033, 0, 2 + LAT, 5);

        // reset during the ISSUE cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h300;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_issue_en_before", {31'd0, data_en}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_issue_en", {31'd0, data_en}, 32'd0);
        chk("rst_issue_wen", {28'd0, data_wen}, 32'd0);
        chk("rst_issue_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
